write_pointer_full: RTL and testbench

- Write-domain half of the asynchronous FIFO.
- Maintains the binary and Gray write pointers and drives the memory write address.
- Generates registered full, almost-full, free-space count and sticky overflow flags.
- Input is the read pointer after it has been double-synchronised into the write clock domain.
- Pairs with the read-side pointer/empty block; the two blocks exchange Gray pointers through two-flop synchronisers.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_gray2bin.sv | 13 +
 rtl/write_pointer_full.sv | 82 ++++++++
 tb/tb_write_pointer_full.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks: default sizing and Gray/binary
// conversion used by both the write-side and read-side pointer logic.
package fifo_pkg;

    localparam int unsigned AddrSizeDefault = 4;

    // Operands are zero-extended to 32 bits; callers size-cast the result back down.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned Width = AddrSizeDefault + 1
) (
    input  logic [Width-1:0] gray_i,
    output logic [Width-1:0] bin_o
);

    assign bin_o = Width'(gray2bin(32'(gray_i)));

endmodule

// File: rtl/write_pointer_full.sv
// Write-domain pointer block of the asynchronous FIFO: binary/Gray write pointers, memory
// write address and registered full, almost-full, free-count and sticky overflow flags.
module write_pointer_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = AddrSizeDefault,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                winc,
    input  logic                woverflow_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wfree,
    output logic                woverflow
);

    localparam int unsigned PtrW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] Depth       = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AfullMargin = PtrW'(AFULL_MARGIN);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wfree_q, wfree_d;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic              woverflow_q, woverflow_d;

    logic              wen;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] full_ref;

    fifo_gray2bin #(
        .Width (PtrW)
    ) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (rbin_s)
    );

    // Writer is full when its Gray pointer equals the read pointer with the top two bits inverted.
    assign full_ref = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign wen      = winc & ~wfull_q;

    always_comb begin
        wbin_d      = wbin_q + PtrW'(wen);
        wptr_d      = PtrW'(bin2gray(32'(wbin_d)));
        wfull_d     = (wptr_d == full_ref);
        wfree_d     = Depth - (wbin_d - rbin_s);
        wafull_d    = (wfree_d <= AfullMargin);
        woverflow_d = (winc & wfull_q) | (woverflow_q & ~woverflow_clr);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q      <= '0;
            wptr_q      <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            wfree_q     <= Depth;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_q      <= wptr_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            wfree_q     <= wfree_d;
            woverflow_q <= woverflow_d;
        end
    end

    assign waddr     = wbin_q[ADDRSIZE-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wfree     = wfree_q;
    assign woverflow = woverflow_q;

endmodule

// File: tb/tb_write_pointer_full.sv
// Self-checking bench for write_pointer_full: occupancy-based reference model, per-cycle
// compare process, directed scenarios and randomized traffic.
module tb_write_pointer_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic [4:0] wq2_rptr = '0;
    logic       winc = 1'b0;
    logic       woverflow_clr = 1'b0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wfree;
    logic       woverflow;

    write_pointer_full #(
        .ADDRSIZE     (4),
        .AFULL_MARGIN (2)
    ) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .wq2_rptr      (wq2_rptr),
        .winc          (winc),
        .woverflow_clr (woverflow_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .wafull        (wafull),
        .wfree         (wfree),
        .woverflow     (woverflow)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model: count of accepted writes and the bench's read count, both mod 32.
    int m_wr  = 0;
    int tb_rd = 0;
    int m_free = 16;
    bit m_full = 1'b0;
    bit m_afull = 1'b0;
    bit m_ovf = 1'b0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int occupancy();
        return (m_wr - tb_rd) & 31;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            m_wr    = 0;
            m_free  = 16;
            m_full  = 1'b0;
            m_afull = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (winc && m_full) m_ovf = 1'b1;
            else if (woverflow_clr) m_ovf = 1'b0;
            if (winc && !m_full) m_wr = (m_wr + 1) % 32;
            m_free  = 16 - occupancy();
            m_full  = (m_free == 0);
            m_afull = (m_free <= 2);
        end
    end

    always @(negedge wclk) begin
        if (chk_en) begin
            chk("waddr", waddr, m_wr % 16);
            chk("wptr", wptr, gray(m_wr));
            chk("wfull", wfull, m_full);
            chk("wafull", wafull, m_afull);
            chk("wfree", wfree, m_free);
            chk("woverflow", woverflow, m_ovf);
        end
    end

    task automatic cyc(input logic inc, input logic clr);
        winc = inc;
        woverflow_clr = clr;
        @(negedge wclk);
        #1;
    endtask

    task automatic set_rd(input int rd);
        tb_rd = rd % 32;
        wq2_rptr = 5'(gray(tb_rd));
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        set_rd(0);
        winc = 1'b0;
        woverflow_clr = 1'b0;
        repeat (2) @(negedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    initial begin
        int writes;
        int rd_pct;
        do_reset();
        chk_en = 1'b1;

        cyc(0, 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_wafull", wafull, 0);
        chk("rst_wfree", wfree, 16);
        chk("rst_wovf", woverflow, 0);

        for (int i = 0; i < 16; i++) begin
            chk("fill_waddr", waddr, i);
            cyc(1, 0);
            if (i == 12) chk("fill_wafull13", wafull, 0);
            if (i == 13) begin
                chk("fill_wafull14", wafull, 1);
                chk("fill_wfree14", wfree, 2);
            end
            if (i == 14) chk("fill_wfull15", wfull, 0);
        end
        chk("full_wfull", wfull, 1);
        chk("full_wptr", wptr, 5'b11000);
        chk("full_wfree", wfree, 0);

        cyc(1, 0);
        chk("ovf_wptr", wptr, 5'b11000);
        chk("ovf_set", woverflow, 1);
        cyc(0, 1);
        chk("ovf_clr", woverflow, 0);
        cyc(1, 0);
        cyc(1, 1);
        chk("ovf_set_prio", woverflow, 1);

        set_rd(1);
        chk("rd1_rptr", wq2_rptr, 5'b00001);
        cyc(0, 0);
        chk("rd1_wfull", wfull, 0);
        chk("rd1_wfree", wfree, 1);
        chk("rd1_wafull", wafull, 1);
        chk("rd1_waddr", waddr, 0);
        cyc(1, 0);
        chk("rd1_refull", wfull, 1);

        // Asynchronous reset mid-cycle while full.
        winc = 1'b1;
        @(posedge wclk);
        #3;
        wrst = 1'b1;
        #1;
        chk("arst_wptr", wptr, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wfull", wfull, 0);
        chk("arst_wafull", wafull, 0);
        chk("arst_wfree", wfree, 16);
        chk("arst_wovf", woverflow, 0);
        do_reset();

        writes = 0;
        while (writes < 40) begin
            if (occupancy() >= 8) set_rd(tb_rd + 1);
            cyc(1, 0);
            writes++;
            if (writes == 16) chk("wrap_msb16", wptr[4], 1);
            if (writes == 31) chk("wrap_msb31", wptr[4], 1);
            if (writes == 32) chk("wrap_msb32", wptr[4], 0);
            chk("wrap_nofull", wfull, 0);
            chk("wrap_wfree", wfree, 16 - occupancy());
        end

        rd_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rd_pct = (rd_pct == 30) ? 75 : 30;
            if (occupancy() > 0 && $urandom_range(0, 99) < rd_pct) set_rd(tb_rd + 1);
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
